intel_temp_sequencer: RTL

// - Drives the FPGA on-die temperature sense diode (TSD): pulses clear, holds enable until tsdcaldone,

---
 rtl/intel_temp_pkg.sv | 40 ++++
 rtl/intel_temp_sequencer_if.sv | 19 +
 rtl/intel_temp_avg.sv | 56 +++++
 rtl/intel_temp_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/intel_temp_pkg.sv
// Shared types, CSR map and status packing for the on-die temperature sequencer.
package intel_temp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    CONVERT = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  localparam int STAT_AVG_VALID = 16;
  localparam int STAT_ALARM     = 17;
  localparam int STAT_TIMEOUT   = 18;
  localparam int STAT_BUSY      = 19;

  localparam int CTRL_PERIODIC = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_IRQ_EN   = 2;

  function automatic int acc_width(input int avg_log2);
    return 8 + avg_log2;
  endfunction

  function automatic logic [31:0] status_word(
    input logic [7:0] last,
    input logic [7:0] avg,
    input logic       avg_valid,
    input logic       alarm,
    input logic       timeout,
    input logic       busy
  );
    return {12'd0, busy, timeout, alarm, avg_valid, avg, last};
  endfunction

endpackage

// File: rtl/intel_temp_sequencer_if.sv
// Avalon-MM slave bus bundle for the temperature sequencer CSR block.
interface intel_temp_sequencer_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/intel_temp_avg.sv
// Block averager over 2**AVG_LOG2 TSD samples with hysteretic over-temperature alarm.
module intel_temp_avg
  import intel_temp_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sample_valid,
  input  logic [7:0] i_sample,
  input  logic [7:0] i_hi,
  input  logic [7:0] i_lo,
  output logic [7:0] o_avg,
  output logic       o_avg_valid,
  output logic       o_alarm
);

  localparam int ACC_W = acc_width(AVG_LOG2);
  localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] w_sum;
  logic [7:0]       w_avg_new;
  logic             w_block_done;

  assign w_sum        = r_acc + ACC_W'(i_sample);
  assign w_avg_new    = w_sum[ACC_W-1:AVG_LOG2];
  assign w_block_done = (r_cnt == CW'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      o_avg       <= '0;
      o_avg_valid <= 1'b0;
      o_alarm     <= 1'b0;
    end else if (i_sample_valid) begin
      if (w_block_done) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        o_avg       <= w_avg_new;
        o_avg_valid <= 1'b1;
        // Set test first so overlapping thresholds resolve to alarm.
        if (w_avg_new >= i_hi)
          o_alarm <= 1'b1;
        else if (w_avg_new <= i_lo)
          o_alarm <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/intel_temp_sequencer.sv
// TSD conversion sequencer: CSR decode, period timer, oneshot pending flag,
// clear/convert/capture FSM and averaging/alarm sub-block.
module intel_temp_sequencer
  import intel_temp_pkg::*;
#(
  parameter int CLR_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int AVG_LOG2       = 3,
  parameter int PERIOD_W       = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  intel_temp_sequencer_if.slave  avs,
  output logic                   tsd_ce,
  output logic                   tsd_clr,
  input  logic [7:0]             tsdcalo,
  input  logic                   tsdcaldone,
  output logic                   irq
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > CLR_CYCLES) ? TIMEOUT_CYCLES : CLR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_periodic_en, r_irq_en, r_pend, r_timeout, r_irq, r_rvalid;
  logic [PERIOD_W-1:0] r_period, r_per_cnt;
  logic [7:0]          r_hi, r_lo, r_last;
  logic [31:0]         r_rdata;

  logic                w_wr_status, w_wr_ctrl, w_wr_period, w_wr_thresh;
  logic                w_en_rise, w_oneshot_wr, w_tick, w_start;
  logic                w_capture, w_timeout_evt, w_busy;
  logic                w_clr_done, w_tmo_reached;
  logic [PERIOD_W-1:0] w_wr_period_val, w_period_eff, w_reload_val;
  logic [7:0]          w_avg;
  logic                w_avg_valid, w_alarm;
  logic [31:0]         w_rdata;
  logic                w_unused_wdata;

  assign w_wr_status  = avs.avs_write && (avs.avs_address == ADDR_STATUS);
  assign w_wr_ctrl    = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign w_wr_period  = avs.avs_write && (avs.avs_address == ADDR_PERIOD);
  assign w_wr_thresh  = avs.avs_write && (avs.avs_address == ADDR_THRESH);
  assign w_en_rise    = w_wr_ctrl && avs.avs_writedata[CTRL_PERIODIC] && !r_periodic_en;
  assign w_oneshot_wr = w_wr_ctrl && avs.avs_writedata[CTRL_ONESHOT];
  assign w_unused_wdata = ^avs.avs_writedata[31:16];

  // PERIOD of zero behaves as one so the timer can never stall.
  assign w_wr_period_val = avs.avs_writedata[PERIOD_W-1:0];
  assign w_period_eff    = (r_period == '0) ? PERIOD_W'(1) : r_period;
  assign w_reload_val    = w_wr_period ?
                           ((w_wr_period_val == '0) ? PERIOD_W'(1) : w_wr_period_val) :
                           w_period_eff;
  assign w_tick          = r_periodic_en && (r_per_cnt <= PERIOD_W'(1));

  assign w_busy        = (r_state != IDLE);
  assign w_start       = (r_state == IDLE) && (w_tick || r_pend);
  assign w_capture     = (r_state == CAPTURE);
  assign w_clr_done    = (r_cnt == CNT_W'(CLR_CYCLES - 1));
  assign w_tmo_reached = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_timeout_evt = (r_state == CONVERT) && !tsdcaldone && w_tmo_reached;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_periodic_en <= 1'b0;
      r_irq_en      <= 1'b0;
      r_period      <= '0;
      r_hi          <= 8'hFF;
      r_lo          <= 8'hFF;
      r_per_cnt     <= '0;
      r_pend        <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_periodic_en <= avs.avs_writedata[CTRL_PERIODIC];
        r_irq_en      <= avs.avs_writedata[CTRL_IRQ_EN];
      end
      if (w_wr_period)
        r_period <= w_wr_period_val;
      if (w_wr_thresh) begin
        r_hi <= avs.avs_writedata[7:0];
        r_lo <= avs.avs_writedata[15:8];
      end
      if (w_wr_period || w_en_rise)
        r_per_cnt <= w_reload_val;
      else if (r_periodic_en)
        r_per_cnt <= w_tick ? w_period_eff : r_per_cnt - 1'b1;
      // A oneshot request arriving on the consuming cycle is kept as a new request.
      r_pend <= (r_pend && !w_start) || w_oneshot_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= ((w_state_next != r_state) || (r_state == IDLE)) ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = CLEAR;
      CLEAR:   if (w_clr_done) w_state_next = CONVERT;
      CONVERT: begin
        if (tsdcaldone)         w_state_next = CAPTURE;
        else if (w_tmo_reached) w_state_next = IDLE;
      end
      CAPTURE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    tsd_clr = 1'b0;
    tsd_ce  = 1'b0;
    case (r_state)
      CLEAR:   tsd_clr = 1'b1;
      CONVERT: tsd_ce  = 1'b1;
      default: ;
    endcase
  end

  // A W1C landing together with a fresh timeout leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last    <= '0;
      r_timeout <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_capture)
        r_last <= tsdcalo;
      r_timeout <= w_timeout_evt ||
                   (r_timeout && !(w_wr_status && avs.avs_writedata[STAT_TIMEOUT]));
      r_irq     <= w_alarm && r_irq_en;
    end
  end

  assign irq = r_irq;

  intel_temp_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk            (clk),
    .rst_n          (reset_n),
    .i_sample_valid (w_capture),
    .i_sample       (tsdcalo),
    .i_hi           (r_hi),
    .i_lo           (r_lo),
    .o_avg          (w_avg),
    .o_avg_valid    (w_avg_valid),
    .o_alarm        (w_alarm)
  );

  always_comb begin
    w_rdata = '0;
    case (avs.avs_address)
      ADDR_STATUS: w_rdata = status_word(r_last, w_avg, w_avg_valid, w_alarm, r_timeout, w_busy);
      ADDR_CTRL:   w_rdata = {29'd0, r_irq_en, 1'b0, r_periodic_en};
      ADDR_PERIOD: w_rdata = 32'(r_period);
      ADDR_THRESH: w_rdata = {16'd0, r_lo, r_hi};
      default:     w_rdata = '0;
    endcase
  end

  // Readdata is sampled from pre-write state, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= avs.avs_read;
      if (avs.avs_read)
        r_rdata <= w_rdata;
    end
  end

  assign avs.avs_readdata      = r_rdata;
  assign avs.avs_readdatavalid = r_rvalid;

endmodule
